// File: rtl/tmds_capture_ctrl.sv
// tmds_capture_ctrl
// Frame-aligned capture of decoded TMDS symbols into a 40-bit capture FIFO,
// followed by operator-driven readout (one FIFO word per step press).
// Runs entirely in the recovered pixel-clock domain.
//
// Ports:
//   clk, rst            pixel clock, synchronous active-high reset
//   pll_lckd            decoder PLL lock; loss aborts any busy state
//   vsync, vde, sdata   decoded video timing and {red, green, blue} symbols
//   arm, step           asynchronous buttons (capture start / pop one word)
//   fifo_full/empty     FIFO status
//   fifo_rst            FIFO reset, held while flushing
//   fifo_wr_en/din      registered write port, din = {sdata, sample index}
//   fifo_rd_en          single-cycle registered pop
//   busy, done          status (registered)
//   ovf, lock_err       sticky error flags, cleared on rst or on re-arm
//   wcount              words written in the current capture
module tmds_capture_ctrl #(
    parameter int NWORDS    = 512,
    parameter int LINE_SKIP = 0,
    parameter int FLUSH_CYC = 8,
    parameter bit VS_POL    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pll_lckd,
    input  logic        vsync,
    input  logic        vde,
    input  logic [29:0] sdata,
    input  logic        arm,
    input  logic        step,
    input  logic        fifo_full,
    input  logic        fifo_empty,
    output logic        fifo_rst,
    output logic        fifo_wr_en,
    output logic [39:0] fifo_din,
    output logic        fifo_rd_en,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic        lock_err,
    output logic [9:0]  wcount
);

    typedef enum logic [2:0] {
        S_IDLE, S_FLUSH, S_WAIT_FRAME, S_WAIT_LINE, S_CAPTURE, S_DONE
    } state_t;

    localparam logic [15:0] FLUSH_LAST = 16'(FLUSH_CYC - 1);
    localparam logic [15:0] SKIP_W     = 16'(LINE_SKIP);
    localparam logic [9:0]  NW_LAST    = 10'(NWORDS - 1);

    state_t      state, state_nxt;
    logic [1:0]  arm_sync, step_sync;
    logic        arm_d, step_d, arm_p, step_p;
    logic        vs_d, vde_d;
    logic [15:0] flush_cnt, line_cnt;

    logic vs_n, frame_start, line_end, busy_st, skip_met;
    logic issue, enter_flush, rd_go, set_ovf, set_lock, busy_nxt, done_nxt;

    // Video edge detection; vsync is normalised so frame start is always a rising edge.
    assign vs_n        = (vsync == VS_POL);
    assign frame_start = vs_n & ~vs_d;
    assign line_end    = vde_d & ~vde;
    assign busy_st     = (state == S_FLUSH) || (state == S_WAIT_FRAME) ||
                         (state == S_WAIT_LINE) || (state == S_CAPTURE);
    // Include the line end seen this cycle so the last skipped line is not
    // counted a cycle late.
    assign skip_met    = (line_cnt == SKIP_W) ||
                         (line_end && ((line_cnt + 16'd1) == SKIP_W));

    // Button synchronisers + rising-edge pulse (3 cycles edge-to-pulse).
    always_ff @(posedge clk) begin
        if (rst) begin
            arm_sync  <= '0;
            step_sync <= '0;
            arm_d     <= 1'b0;
            step_d    <= 1'b0;
            arm_p     <= 1'b0;
            step_p    <= 1'b0;
            vs_d      <= 1'b0;
            vde_d     <= 1'b0;
        end else begin
            arm_sync  <= {arm_sync[0], arm};
            step_sync <= {step_sync[0], step};
            arm_d     <= arm_sync[1];
            step_d    <= step_sync[1];
            arm_p     <= arm_sync[1] & ~arm_d;
            step_p    <= step_sync[1] & ~step_d;
            vs_d      <= vs_n;
            vde_d     <= vde;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:       if (arm_p && pll_lckd) state_nxt = S_FLUSH;
            S_FLUSH:      if (flush_cnt == FLUSH_LAST) state_nxt = S_WAIT_FRAME;
            S_WAIT_FRAME: if (frame_start) state_nxt = S_WAIT_LINE;
            S_WAIT_LINE:  if (skip_met) state_nxt = S_CAPTURE;
            S_CAPTURE: begin
                if (vde && fifo_full)              state_nxt = S_DONE;
                else if (vde && wcount == NW_LAST) state_nxt = S_DONE;
            end
            S_DONE:       if (arm_p) state_nxt = S_FLUSH;
            default:      state_nxt = S_IDLE;
        endcase
        // Lock loss overrides everything while busy.
        if (busy_st && !pll_lckd) state_nxt = S_IDLE;
    end

    // Output / control decode
    always_comb begin
        fifo_rst    = (state == S_FLUSH);
        issue       = (state == S_CAPTURE) && vde && !fifo_full && pll_lckd;
        set_ovf     = (state == S_CAPTURE) && vde && fifo_full && pll_lckd;
        set_lock    = busy_st && !pll_lckd;
        enter_flush = (state_nxt == S_FLUSH) && (state != S_FLUSH);
        // A simultaneous accepted arm wins over a step.
        rd_go       = step_p && !fifo_empty && !enter_flush &&
                      ((state == S_IDLE) || (state == S_DONE));
        busy_nxt    = (state_nxt == S_FLUSH) || (state_nxt == S_WAIT_FRAME) ||
                      (state_nxt == S_WAIT_LINE) || (state_nxt == S_CAPTURE);
        done_nxt    = (state_nxt == S_DONE);
    end

    // Datapath, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt  <= '0;
            line_cnt   <= '0;
            wcount     <= '0;
            ovf        <= 1'b0;
            lock_err   <= 1'b0;
            fifo_wr_en <= 1'b0;
            fifo_din   <= '0;
            fifo_rd_en <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            flush_cnt <= (state == S_FLUSH) ? flush_cnt + 16'd1 : 16'd0;
            if (enter_flush) begin
                wcount   <= '0;
                line_cnt <= '0;
                ovf      <= 1'b0;
                lock_err <= 1'b0;
            end else begin
                if (issue)    wcount   <= wcount + 10'd1;
                if (set_ovf)  ovf      <= 1'b1;
                if (set_lock) lock_err <= 1'b1;
                if (state == S_WAIT_LINE && line_end) line_cnt <= line_cnt + 16'd1;
            end
            fifo_wr_en <= issue;
            if (issue) fifo_din <= {sdata, wcount};
            fifo_rd_en <= rd_go;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_tmds_capture_ctrl.sv
`timescale 1ns/1ps
module tb_tmds_capture_ctrl;
  localparam int NW0 = 16, NW1 = 700, SK1 = 2, FLUSH = 8;
  localparam int ACT = 640, HBL = 16, NLINES = 5;

  typedef struct { logic [39:0] din; longint cyc; } exp_t;

  logic clk = 1'b0, rst = 1'b1, pll_lckd = 1'b1, vsync = 1'b0, vde = 1'b0;
  logic [29:0] sdata = '0;
  logic arm0 = 1'b0, arm1 = 1'b0, step0 = 1'b0, step1 = 1'b0;
  logic fifo_full = 1'b0, fifo_empty = 1'b0;

  logic [1:0] o_rst, o_wr, o_rd, o_busy, o_done, o_ovf, o_lerr;
  logic [39:0] o_din [2];
  logic [9:0]  o_wc  [2];

  int n_tests = 0, n_fail = 0;
  longint cyc = 0;
  exp_t q0[$], q1[$];
  // reference model: 0 idle/done, 1 armed waiting for frame, 2 frame seen
  int m_st[2], m_lines[2], m_idx[2];
  int trig_full = -1, trig_lock = -1, trig_rst = -1, trig_step = -1;
  logic vs_prev = 1'b0, de_prev = 1'b0;
  int rd_cnt = 0;
  int flushes[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tmds_capture_ctrl #(.NWORDS(NW0), .LINE_SKIP(0), .FLUSH_CYC(FLUSH), .VS_POL(1'b1)) u0 (
    .clk(clk), .rst(rst), .pll_lckd(pll_lckd), .vsync(vsync), .vde(vde), .sdata(sdata),
    .arm(arm0), .step(step0), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_rst(o_rst[0]), .fifo_wr_en(o_wr[0]), .fifo_din(o_din[0]), .fifo_rd_en(o_rd[0]),
    .busy(o_busy[0]), .done(o_done[0]), .ovf(o_ovf[0]), .lock_err(o_lerr[0]), .wcount(o_wc[0]));

  tmds_capture_ctrl #(.NWORDS(NW1), .LINE_SKIP(SK1), .FLUSH_CYC(FLUSH), .VS_POL(1'b1)) u1 (
    .clk(clk), .rst(rst), .pll_lckd(pll_lckd), .vsync(vsync), .vde(vde), .sdata(sdata),
    .arm(arm1), .step(step1), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_rst(o_rst[1]), .fifo_wr_en(o_wr[1]), .fifo_din(o_din[1]), .fifo_rd_en(o_rd[1]),
    .busy(o_busy[1]), .done(o_done[1]), .ovf(o_ovf[1]), .lock_err(o_lerr[1]), .wcount(o_wc[1]));

  task automatic check(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int nw(input int d);
    return (d == 0) ? NW0 : NW1;
  endfunction

  function automatic int skip(input int d);
    return (d == 0) ? 0 : SK1;
  endfunction

  task automatic m_arm(input int d);
    if (pll_lckd && m_st[d] == 0) begin
      m_st[d] = 1;
      m_idx[d] = 0;
    end
  endtask

  // One pixel clock: apply triggers, drive video, advance the model.
  task automatic drive_cycle(input logic vs, input logic de);
    exp_t e;
    @(posedge clk); #1;
    if (m_st[0] == 2 && de) begin
      if (m_idx[0] == trig_full) fifo_full = 1'b1;
      if (m_idx[0] == trig_lock) pll_lckd = 1'b0;
      if (m_idx[0] == trig_rst)  rst = 1'b1;
      if (m_idx[0] == trig_step) step0 = 1'b1;
    end
    vsync = vs;
    vde = de;
    sdata = 30'($urandom);
    for (int d = 0; d < 2; d++) begin
      if (rst || !pll_lckd) m_st[d] = 0;
      else if (vs && !vs_prev && m_st[d] == 1) begin
        m_st[d] = 2;
        m_lines[d] = 0;
      end else if (m_st[d] == 2) begin
        if (!de && de_prev) m_lines[d]++;
        if (de && m_lines[d] >= skip(d)) begin
          if (fifo_full) m_st[d] = 0;
          else begin
            e.din = {sdata, 10'(m_idx[d])};
            e.cyc = cyc + 1;
            if (d == 0) q0.push_back(e); else q1.push_back(e);
            m_idx[d]++;
            if (m_idx[d] == nw(d)) m_st[d] = 0;
          end
        end
      end
    end
    vs_prev = vs;
    de_prev = de;
  endtask

  task automatic run_frame(input int tf, input int tl, input int tr, input int ts);
    trig_full = tf; trig_lock = tl; trig_rst = tr; trig_step = ts;
    repeat (10) drive_cycle(1'b1, 1'b0);
    repeat (20) drive_cycle(1'b0, 1'b0);
    for (int l = 0; l < NLINES; l++) begin
      repeat (ACT) drive_cycle(1'b0, 1'b1);
      repeat (HBL) drive_cycle(1'b0, 1'b0);
    end
    repeat (10) drive_cycle(1'b0, 1'b0);
    trig_full = -1; trig_lock = -1; trig_rst = -1; trig_step = -1;
  endtask

  task automatic press_arm(input int d);
    if (d == 0) arm0 = 1'b1; else arm1 = 1'b1;
    m_arm(d);
    repeat (10) drive_cycle(1'b0, 1'b0);
    arm0 = 1'b0; arm1 = 1'b0;
    repeat (10) drive_cycle(1'b0, 1'b0);
  endtask

  task automatic press_step();
    step0 = 1'b1;
    repeat (20) drive_cycle(1'b0, 1'b0);
    step0 = 1'b0;
    repeat (10) drive_cycle(1'b0, 1'b0);
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    int run[2];
    logic rst_prev, rd_prev, unl_prev;
    run[0] = 0; run[1] = 0;
    rst_prev = 1'b0; rd_prev = 1'b0; unl_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_prev)
        check("reset_outputs_zero",
              |{o_rst, o_wr, o_rd, o_busy, o_done, o_ovf, o_lerr,
                o_din[0], o_din[1], o_wc[0], o_wc[1]}, 0);
      if (unl_prev) begin
        check("unlocked_not_busy", o_busy[0], 0);
        check("unlocked_no_write", o_wr[0], 0);
      end
      if (o_wr[0]) begin
        check("wr0_expected_pending", q0.size() != 0, 1);
        if (q0.size() != 0) begin
          e = q0.pop_front();
          check("wr0_din", o_din[0], e.din);
          check("wr0_cycle", cyc, e.cyc);
        end
      end
      if (o_wr[1]) begin
        check("wr1_expected_pending", q1.size() != 0, 1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          check("wr1_din", o_din[1], e.din);
          check("wr1_cycle", cyc, e.cyc);
        end
      end
      if (o_rd[0]) begin
        rd_cnt++;
        check("rd_single_cycle", rd_prev, 0);
      end
      for (int d = 0; d < 2; d++) begin
        if (o_rst[d]) run[d]++;
        else if (run[d] != 0) begin
          check("flush_length", run[d], FLUSH);
          run[d] = 0;
          flushes[d]++;
        end
      end
      rst_prev = rst;
      rd_prev  = o_rd[0];
      unl_prev = !pll_lckd;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_base, fl_base;
    for (int d = 0; d < 2; d++) begin
      m_st[d] = 0; m_lines[d] = 0; m_idx[d] = 0; flushes[d] = 0;
    end
    repeat (4) drive_cycle(1'b0, 1'b0);
    rst = 1'b0;
    repeat (4) drive_cycle(1'b0, 1'b0);

    // Basic capture, with a step press during CAPTURE that must be ignored
    rd_base = rd_cnt;
    press_arm(0);
    @(negedge clk);
    check("basic_busy_armed", o_busy[0], 1);
    run_frame(-1, -1, -1, 1);
    step0 = 1'b0;
    repeat (4) drive_cycle(1'b0, 1'b0);
    @(negedge clk);
    check("basic_done", o_done[0], 1);
    check("basic_busy", o_busy[0], 0);
    check("basic_wcount", o_wc[0], NW0);
    check("basic_ovf", o_ovf[0], 0);
    check("basic_flushes", flushes[0], 1);
    check("step_in_capture_ignored", rd_cnt - rd_base, 0);

    // Line skip: capture spans line 3 into line 4
    press_arm(1);
    run_frame(-1, -1, -1, -1);
    @(negedge clk);
    check("skip_done", o_done[1], 1);
    check("skip_busy", o_busy[1], 0);
    check("skip_wcount", o_wc[1], NW1);
    check("skip_other_untouched", o_wc[0], NW0);

    // Readout in DONE
    rd_base = rd_cnt;
    for (int i = 0; i < 4; i++) press_step();
    @(negedge clk);
    check("readout_pulses", rd_cnt - rd_base, 4);
    fifo_empty = 1'b1;
    rd_base = rd_cnt;
    press_step();
    @(negedge clk);
    check("readout_empty_ignored", rd_cnt - rd_base, 0);
    fifo_empty = 1'b0;

    // Lock loss after 3 writes
    press_arm(0);
    run_frame(-1, 3, -1, -1);
    @(negedge clk);
    check("lock_busy", o_busy[0], 0);
    check("lock_done", o_done[0], 0);
    check("lock_err_set", o_lerr[0], 1);
    check("lock_wcount", o_wc[0], 3);

    // Arm while unlocked is ignored
    fl_base = flushes[0];
    press_arm(0);
    repeat (10) drive_cycle(1'b0, 1'b0);
    @(negedge clk);
    check("unlocked_arm_idle", o_busy[0], 0);
    check("unlocked_arm_no_flush", flushes[0] - fl_base, 0);
    pll_lckd = 1'b1;
    repeat (4) drive_cycle(1'b0, 1'b0);

    // Overflow after 5 writes
    press_arm(0);
    @(negedge clk);
    check("rearm_clears_lock_err", o_lerr[0], 0);
    run_frame(5, -1, -1, -1);
    fifo_full = 1'b0;
    @(negedge clk);
    check("ovf_set", o_ovf[0], 1);
    check("ovf_done", o_done[0], 1);
    check("ovf_wcount", o_wc[0], 5);

    // Arm and step together in DONE: arm wins
    rd_base = rd_cnt;
    arm0 = 1'b1; step0 = 1'b1;
    m_arm(0);
    repeat (5) drive_cycle(1'b0, 1'b0);
    @(negedge clk);
    check("rearm_in_flush", o_rst[0], 1);
    check("rearm_ovf_clear", o_ovf[0], 0);
    check("rearm_lock_err_clear", o_lerr[0], 0);
    repeat (5) drive_cycle(1'b0, 1'b0);
    arm0 = 1'b0; step0 = 1'b0;
    repeat (15) drive_cycle(1'b0, 1'b0);
    @(negedge clk);
    check("rearm_step_dropped", rd_cnt - rd_base, 0);
    check("rearm_busy", o_busy[0], 1);

    // Reset mid-capture after 4 writes (monitor checks outputs are zero)
    run_frame(-1, -1, 4, -1);
    rst = 1'b0;
    repeat (10) drive_cycle(1'b0, 1'b0);
    @(negedge clk);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    check("post_reset_idle", o_busy[0], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
